// File: rtl/cascade_ctrl_pkg.sv
// Shared types and constants for the cascaded counter chain controller.
package cascade_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned WORD_W     = NUM_DIGITS * NIB_W;

    typedef enum logic [1:0] {
        OP_RUN     = 2'd0,
        OP_STOP    = 2'd1,
        OP_LOAD    = 2'd2,
        OP_SET_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LOAD
    } state_e;

    function automatic logic [NIB_W-1:0] nibble_of(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx);
        return word[idx*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/cascade_ctrl_tick_gen.sv
// Count-enable prescaler: owns the divisor and emits a registered tick once per div counts.
module tick_gen #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_div,
    input  logic [DIV_W-1:0] div_in,
    input  logic             clear,
    input  logic             advance,
    input  logic             run_next,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_INIT = (DIV_RESET == 0) ? ONE : DIV_W'(DIV_RESET);

    logic [DIV_W-1:0] div_q, div_n, count, count_n;

    always_comb begin
        div_n = div_q;
        if (set_div) begin
            div_n = (div_in == '0) ? ONE : div_in;
        end
        count_n = count;
        if (clear) begin
            count_n = '0;
        end else if (advance) begin
            count_n = (count == div_q - ONE) ? '0 : count + ONE;
        end
    end

    // Tick is decided from next-cycle count/divisor so it lines up with the count it represents.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DIV_INIT;
            count <= '0;
            tick  <= 1'b0;
        end else begin
            div_q <= div_n;
            count <= count_n;
            tick  <= run_next && (count_n == div_n - ONE);
        end
    end

endmodule

// File: rtl/cascade_ctrl.sv
// Command-driven sequencer for the four-digit cascaded counter chain.
module cascade_ctrl
    import cascade_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WORD_W-1:0]     cmd_data,
    input  logic                  chain_tc,
    output logic                  cnt_enable,
    output logic                  cnt_up_down,
    output logic                  cnt_selector,
    output logic [NUM_DIGITS-1:0] cnt_load,
    output logic [NIB_W-1:0]      cnt_numload,
    output logic                  busy,
    output logic                  done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_e            state, state_n, ret_state;
    op_e               op;
    logic [WORD_W-1:0] load_data;
    logic [IDX_W-1:0]  load_idx, idx_n;
    logic              oneshot, ready_q, accept, terminal;
    logic              clear, set_div, done_n;

    assign cmd_ready = ready_q && !reset;

    always_comb begin
        op       = op_e'(cmd_op);
        accept   = cmd_valid && cmd_ready;
        terminal = (state == ST_RUN) && oneshot && cnt_enable && chain_tc;
        idx_n    = load_idx + IDX_W'(1);
        state_n  = state;
        clear    = 1'b0;
        set_div  = 1'b0;
        done_n   = terminal;
        if (state == ST_LOAD) begin
            if (load_idx == LAST_IDX) begin
                state_n = ret_state;
            end
        end else begin
            if (terminal) begin
                state_n = ST_IDLE;
            end
            // Any accepted command except STOP pre-empts a one-shot terminal stop.
            if (accept) begin
                done_n = terminal && (op == OP_STOP);
                unique case (op)
                    OP_RUN: begin
                        state_n = ST_RUN;
                        clear   = 1'b1;
                    end
                    OP_STOP: begin
                        state_n = ST_IDLE;
                        clear   = 1'b1;
                    end
                    OP_LOAD: begin
                        state_n = ST_LOAD;
                    end
                    OP_SET_DIV: begin
                        state_n = state;
                        set_div = 1'b1;
                        clear   = 1'b1;
                    end
                endcase
            end
        end
    end

    tick_gen #(
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .set_div  (set_div),
        .div_in   (cmd_data[DIV_W-1:0]),
        .clear    (clear),
        .advance  (state == ST_RUN),
        .run_next (state_n == ST_RUN),
        .tick     (cnt_enable)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ret_state    <= ST_IDLE;
            cnt_up_down  <= 1'b1;
            cnt_selector <= 1'b0;
            oneshot      <= 1'b0;
            load_data    <= '0;
            load_idx     <= '0;
            cnt_load     <= '0;
            cnt_numload  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state   <= state_n;
            busy    <= (state_n != ST_IDLE);
            ready_q <= (state_n != ST_LOAD);
            done    <= done_n;
            if (accept && op == OP_RUN) begin
                cnt_up_down  <= cmd_data[0];
                cnt_selector <= cmd_data[1];
                oneshot      <= cmd_data[2];
            end
            if (accept && op == OP_LOAD) begin
                load_data   <= cmd_data;
                ret_state   <= state;
                load_idx    <= '0;
                cnt_load    <= NUM_DIGITS'(1);
                cnt_numload <= cmd_data[NIB_W-1:0];
            end else if (state == ST_LOAD) begin
                if (load_idx == LAST_IDX) begin
                    cnt_load    <= '0;
                    cnt_numload <= '0;
                end else begin
                    load_idx    <= idx_n;
                    cnt_load    <= cnt_load << 1;
                    cnt_numload <= nibble_of(load_data, idx_n);
                end
            end
        end
    end

endmodule
